// File: rtl/ppi_access_arbiter.sv
// Access sequencer for the k580vv55 PPI. It writes the power-up control word, then
// serves CPU and host requests round-robin with setup/strobe/hold write cycles.
module ppi_access_arbiter #(
  parameter logic [7:0] INIT_MODE  = 8'h82,
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,

  input  logic       host_req,
  input  logic       host_we,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,

  output logic [1:0] ppi_addr,
  output logic       ppi_we_n,
  output logic [7:0] ppi_idata,
  input  logic [7:0] ppi_odata,
  output logic       init_done
);

  if (SETUP_CYC < 1 || SETUP_CYC > 7) begin : g_setup_range
    $error("SETUP_CYC must be within 1..7");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 7) begin : g_strobe_range
    $error("STROBE_CYC must be within 1..7");
  end
  if (INIT_MODE[7] != 1'b1) begin : g_init_mode
    $error("INIT_MODE must be a mode-set control word (bit 7 set)");
  end

  localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;

  logic       last_grant;    // 0 = CPU, 1 = host
  logic       owner;         // requester of the access in flight
  logic       init_access;   // access in flight is the power-up control word
  logic       acc_we;

  logic       pick_valid;
  logic       pick;

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    pick_valid = init_done && (cpu_req || host_req);
    if (cpu_req && host_req) pick = ~last_grant;
    else                     pick = host_req;
  end

  // NOTE: state, counter and outputs use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      S_INIT: begin
        state_next = S_SETUP;
        cnt_next   = 3'd0;
      end
      S_IDLE: begin
        if (pick_valid) begin
          state_next = S_SETUP;
          cnt_next   = 3'd0;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_next   = 3'd0;
          state_next = acc_we ? S_STROBE : S_DONE;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      S_STROBE: begin
        if (cnt == STROBE_LAST) begin
          cnt_next   = 3'd0;
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      S_HOLD: state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: begin
        state_next = S_INIT;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Datapath: PPI bus, request capture, read data and ack pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ppi_addr    <= 2'd0;
      ppi_idata   <= 8'h00;
      ppi_we_n    <= 1'b1;
      cpu_ack     <= 1'b0;
      host_ack    <= 1'b0;
      cpu_rdata   <= 8'h00;
      host_rdata  <= 8'h00;
      init_done   <= 1'b0;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      init_access <= 1'b1;
      acc_we      <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      unique case (state)
        S_INIT: begin
          ppi_addr    <= 2'd3;
          ppi_idata   <= INIT_MODE;
          acc_we      <= 1'b1;
          init_access <= 1'b1;
        end
        S_IDLE: begin
          if (pick_valid) begin
            owner       <= pick;
            last_grant  <= pick;
            init_access <= 1'b0;
            acc_we      <= pick ? host_we    : cpu_we;
            ppi_addr    <= pick ? host_addr  : cpu_addr;
            ppi_idata   <= pick ? host_wdata : cpu_wdata;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            if (acc_we) begin
              ppi_we_n <= 1'b0;
            end else if (!init_access) begin
              // Reads finish straight from SETUP, so the ack is raised here.
              if (owner) begin
                host_rdata <= ppi_odata;
                host_ack   <= 1'b1;
              end else begin
                cpu_rdata <= ppi_odata;
                cpu_ack   <= 1'b1;
              end
            end
          end
        end
        S_STROBE: begin
          if (cnt == STROBE_LAST) ppi_we_n <= 1'b1;
        end
        S_HOLD: begin
          if (!init_access) begin
            if (owner) host_ack <= 1'b1;
            else       cpu_ack  <= 1'b1;
          end
        end
        S_DONE: begin
          if (init_access) init_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_access_arbiter.sv
// Bench for ppi_access_arbiter: a small k580vv55 register model, a table of single
// accesses, hand-written contention/reset/field-capture sequences and an ack scoreboard.
module tb_ppi_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_ack;
  logic [1:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic [1:0] ppi_addr;
  logic       ppi_we_n;
  logic [7:0] ppi_idata, ppi_odata;
  logic       init_done;

  always #5 clk = ~clk;

  ppi_access_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ppi_addr(ppi_addr), .ppi_we_n(ppi_we_n), .ppi_idata(ppi_idata), .ppi_odata(ppi_odata),
    .init_done(init_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PPI model: mode word resets the output ports; bit-set/reset acts on port C.
  logic [7:0] opa = 8'h00, opc = 8'h00, mode = 8'h9B, ipb = 8'h00;
  int         fall_cnt = 0;

  always @(negedge ppi_we_n) begin
    fall_cnt <= fall_cnt + 1;
    case (ppi_addr)
      2'd0: opa <= ppi_idata;
      2'd2: opc <= ppi_idata;
      2'd3: begin
        if (ppi_idata[7]) begin
          mode <= ppi_idata;
          opa  <= 8'h00;
          opc  <= 8'h00;
        end else begin
          opc[ppi_idata[3:1]] <= ppi_idata[0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ppi_addr)
      2'd0:    ppi_odata = opa;
      2'd1:    ppi_odata = ipb;
      2'd2:    ppi_odata = opc;
      default: ppi_odata = mode;
    endcase
  end

  // Address and data must already be on the bus one cycle before we_n falls.
  logic [1:0] prev_addr = 2'd0, last_strobe_addr = 2'd0;
  logic [7:0] prev_idata = 8'h00, last_strobe_idata = 8'h00;
  logic       prev_we_n = 1'b1;

  always @(negedge clk) begin
    if (!reset && prev_we_n && !ppi_we_n) begin
      check("setup_addr_stable", 32'(ppi_addr), 32'(prev_addr));
      check("setup_idata_stable", 32'(ppi_idata), 32'(prev_idata));
      last_strobe_addr  <= ppi_addr;
      last_strobe_idata <= ppi_idata;
    end
    prev_we_n  <= ppi_we_n;
    prev_addr  <= ppi_addr;
    prev_idata <= ppi_idata;
  end

  // Scoreboard: expected completions in grant order.
  typedef struct {
    bit         who;
    bit         rd;
    logic [7:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (!reset && (cpu_ack || host_ack)) begin
      check("ack_overlap", 32'(cpu_ack & host_ack), 32'd0);
      check("ack_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ack_owner", 32'(host_ack), 32'(e.who));
        if (e.rd) check("ack_rdata", 32'(e.who ? host_rdata : cpu_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic drive(bit who, bit we, logic [1:0] a, logic [7:0] d, bit req);
    if (who) begin
      host_req = req; host_we = we; host_addr = a; host_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  // Cycles counted inclusively from the IDLE cycle that carries the request; -1 on timeout.
  task automatic wait_ack(bit who, output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (who ? host_ack : cpu_ack) return;
    end
    n = -1;
  endtask

  function automatic logic [7:0] ppi_reg(logic [1:0] a);
    case (a)
      2'd0:    return opa;
      2'd2:    return opc;
      2'd3:    return mode;
      default: return ipb;
    endcase
  endfunction

  typedef struct {
    bit         who;
    bit         we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] ipb;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         n, f0, acks, lows, early;
    logic [7:0] cpu_shadow, host_shadow;

    vecs[0] = '{who: 1'b0, we: 1'b1, addr: 2'd0, wdata: 8'h5A, ipb: 8'h00, exp_rd: 8'h00, exp_lat: 6};
    vecs[1] = '{who: 1'b1, we: 1'b0, addr: 2'd1, wdata: 8'h00, ipb: 8'hC3, exp_rd: 8'hC3, exp_lat: 3};
    vecs[2] = '{who: 1'b0, we: 1'b0, addr: 2'd0, wdata: 8'h00, ipb: 8'h11, exp_rd: 8'h5A, exp_lat: 3};
    vecs[3] = '{who: 1'b1, we: 1'b1, addr: 2'd2, wdata: 8'h3C, ipb: 8'h11, exp_rd: 8'h00, exp_lat: 6};
    vecs[4] = '{who: 1'b0, we: 1'b0, addr: 2'd2, wdata: 8'h00, ipb: 8'h11, exp_rd: 8'h3C, exp_lat: 3};
    vecs[5] = '{who: 1'b1, we: 1'b0, addr: 2'd3, wdata: 8'h00, ipb: 8'h11, exp_rd: 8'h82, exp_lat: 3};

    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd3, 8'h00, 1'b1);   // CPU read pending across reset
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);

    // Reset values and power-up control word.
    repeat (3) @(negedge clk);
    check("rst_we_n", 32'(ppi_we_n), 32'd1);
    check("rst_addr", 32'(ppi_addr), 32'd0);
    check("rst_idata", 32'(ppi_idata), 32'd0);
    check("rst_acks", 32'({cpu_ack, host_ack}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, host_rdata}), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    sb_q.push_back(sb_t'{who: 1'b0, rd: 1'b1, rdata: 8'h82});
    f0 = fall_cnt;
    reset = 1'b0;
    lows = 0; early = 0;
    for (int i = 0; i < 30 && !init_done; i++) begin
      @(negedge clk);
      if (!init_done) begin
        if (!ppi_we_n) lows++;
        if (cpu_ack || host_ack) early++;
      end
    end
    check("t1_init_done", 32'(init_done), 32'd1);
    check("t1_we_low_cycles", 32'(lows), 32'd2);
    check("t1_no_ack_during_init", 32'(early), 32'd0);
    check("t1_init_addr", 32'(last_strobe_addr), 32'd3);
    check("t1_init_data", 32'(last_strobe_idata), 32'h82);
    check("t1_init_falls", 32'(fall_cnt - f0), 32'd1);
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    check("t1_pending_read_lat", 32'(n), 32'd3);
    cpu_shadow  = 8'h82;
    host_shadow = 8'h00;
    @(negedge clk);

    // Single uncontended accesses.
    for (int i = 0; i < 6; i++) begin
      ipb = vecs[i].ipb;
      f0  = fall_cnt;
      sb_q.push_back(sb_t'{who: vecs[i].who, rd: !vecs[i].we, rdata: vecs[i].exp_rd});
      drive(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b1);
      wait_ack(vecs[i].who, n);
      drive(vecs[i].who, 1'b0, 2'd0, 8'h00, 1'b0);
      check($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_we_falls", i), 32'(fall_cnt - f0), vecs[i].we ? 32'd1 : 32'd0);
      if (vecs[i].we) check($sformatf("v%0d_ppi_reg", i), 32'(ppi_reg(vecs[i].addr)), 32'(vecs[i].wdata));
      if (!vecs[i].we) begin
        if (vecs[i].who) host_shadow = vecs[i].exp_rd;
        else             cpu_shadow  = vecs[i].exp_rd;
      end
      check($sformatf("v%0d_cpu_rdata_hold", i), 32'(cpu_rdata), 32'(cpu_shadow));
      check($sformatf("v%0d_host_rdata_hold", i), 32'(host_rdata), 32'(host_shadow));
      @(negedge clk);
    end

    // Contention: last grant was the host, so the CPU goes first and grants alternate.
    ipb = 8'h99;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(sb_t'{who: 1'b0, rd: 1'b0, rdata: 8'h00});
      sb_q.push_back(sb_t'{who: 1'b1, rd: 1'b1, rdata: 8'h99});
    end
    drive(1'b0, 1'b1, 2'd0, 8'hA5, 1'b1);
    drive(1'b1, 1'b0, 2'd1, 8'h00, 1'b1);
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) acks++;
    end
    cpu_req  = 1'b0;
    host_req = 1'b0;
    check("t4_ack_count", 32'(acks), 32'd4);
    check("t4_opa", 32'(opa), 32'hA5);
    @(negedge clk);

    // Reset in the middle of a strobe.
    drive(1'b0, 1'b1, 2'd0, 8'h77, 1'b1);
    for (int i = 0; i < 10 && ppi_we_n; i++) @(negedge clk);
    check("t5_reached_strobe", 32'(ppi_we_n), 32'd0);
    reset = 1'b1;
    #1;
    check("t5_we_n_forced", 32'(ppi_we_n), 32'd1);
    check("t5_no_ack", 32'({cpu_ack, host_ack}), 32'd0);
    check("t5_init_cleared", 32'(init_done), 32'd0);
    @(negedge clk);
    sb_q.push_back(sb_t'{who: 1'b0, rd: 1'b0, rdata: 8'h00});
    f0 = fall_cnt;
    reset = 1'b0;
    for (int i = 0; i < 20 && !init_done; i++) @(negedge clk);
    check("t5_init_done", 32'(init_done), 32'd1);
    check("t5_init_addr", 32'(last_strobe_addr), 32'd3);
    check("t5_init_data", 32'(last_strobe_idata), 32'h82);
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    check("t5_lat_after_init", 32'(n), 32'd6);
    check("t5_falls", 32'(fall_cnt - f0), 32'd2);
    check("t5_opa", 32'(opa), 32'h77);
    @(negedge clk);

    // Bit-set of PC7; the write data is changed right after the grant.
    sb_q.push_back(sb_t'{who: 1'b0, rd: 1'b0, rdata: 8'h00});
    drive(1'b0, 1'b1, 2'd3, 8'h0F, 1'b1);
    @(negedge clk);
    cpu_wdata = 8'hFF;
    wait_ack(1'b0, n);
    cpu_req = 1'b0;
    check("t6_latency", 32'(n + 1), 32'd6);
    check("t6_strobe_idata", 32'(last_strobe_idata), 32'h0F);
    check("t6_opc", 32'(opc), 32'h80);
    check("t6_mode", 32'(mode), 32'h82);
    repeat (3) @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
